mux_scan_reg: RTL and testbench

- Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready handshake.
- Two modes: manual (external select) and auto-scan (round-robin with per-channel dwell time).
- Sits between parallel channel sources (sensor or status buses) and a single downstream consumer.
- Replaces hand-instantiated 4:1 gate-level muxes wherever a channel must be sampled over time.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_scan_ptr.sv | 64 ++++++
 rtl/mux_scan_reg.sv | 100 ++++++++++
 tb/tb_mux_scan_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and the masked round-robin search for the mux_scan_reg block.
package mux_scan_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;
   localparam int   MAX_CH      = 32;

   // First enabled channel strictly after ptr (wrapping); ptr itself when no other is enabled.
   function automatic int next_ch(input int ptr, input logic [MAX_CH-1:0] mask, input int n);
      int res;
      res = ptr;
      for (int k = MAX_CH - 1; k >= 1; k--) begin
         if (k < n && mask[(ptr + k) % n]) res = (ptr + k) % n;
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Scan pointer and dwell counter: emits a sample strobe plus the channel to sample.
module mux_scan_ptr
   import mux_scan_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int DWELL = 3,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic              reg_free,
   input  logic [N_CH-1:0]   ch_mask,
   output logic              strobe,
   output logic [SEL_W-1:0]  samp_ch
);

   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [SEL_W-1:0] ptr_reg, ptr_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             mode_reg;
   logic             mode_change;
   logic             dwell_done;
   logic             any_en;

   assign mode_change = (mode != mode_reg);
   assign dwell_done  = (cnt_reg == CNT_W'(DWELL - 1));
   assign any_en      = |ch_mask;

   // A masked pointer position resolves to the next enabled channel at sample time.
   assign samp_ch = ch_mask[ptr_reg] ? ptr_reg
                  : SEL_W'(next_ch(int'(ptr_reg), MAX_CH'(ch_mask), N_CH));

   assign strobe = (mode == MODE_SCAN) && !mode_change && dwell_done && reg_free && any_en;

   always_comb begin
      ptr_next = ptr_reg;
      cnt_next = cnt_reg;
      if (mode != MODE_SCAN || mode_change) begin
         ptr_next = '0;
         cnt_next = '0;
      end else if (strobe) begin
         ptr_next = SEL_W'(next_ch(int'(samp_ch), MAX_CH'(ch_mask), N_CH));
         cnt_next = '0;
      end else if (!dwell_done) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
      // dwell_done without a strobe: freeze until the output frees up
   end

   always_ff @(posedge clk) begin
      // mode_reg tracks mode through reset so leaving reset is not seen as a switch
      mode_reg <= mode;
      if (rst) begin
         ptr_reg <= '0;
         cnt_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/mux_scan_reg.sv
// N-channel registered mux with manual select and dwell-timed auto-scan.
// Optional channel mask enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_reg
   import mux_scan_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int W     = 8,
   parameter int DWELL = 3,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic [N_CH*W-1:0] in_data,
`ifdef MUX_SCAN_MASK_EN
   input  logic [N_CH-1:0]   ch_mask,
`endif
   input  logic              out_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch
);

   logic [W-1:0]     ch_data [N_CH];
   logic [N_CH-1:0]  mask_v;
   logic             reg_free;
   logic             strobe;
   logic [SEL_W-1:0] samp_ch;
   logic             sel_ok;

   logic             valid_reg, valid_next;
   logic [W-1:0]     data_reg, data_next;
   logic [SEL_W-1:0] ch_reg, ch_next;

`ifdef MUX_SCAN_MASK_EN
   assign mask_v = ch_mask;
`else
   assign mask_v = '1;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_unpack
         assign ch_data[gi] = in_data[gi*W +: W];
      end
   endgenerate

   assign reg_free = !valid_reg || out_ready;
   assign sel_ok   = (int'(sel) < N_CH) && mask_v[sel];

   mux_scan_ptr #(
      .N_CH  (N_CH),
      .DWELL (DWELL),
      .SEL_W (SEL_W)
   ) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .reg_free (reg_free),
      .ch_mask  (mask_v),
      .strobe   (strobe),
      .samp_ch  (samp_ch)
   );

   always_comb begin
      valid_next = valid_reg;
      data_next  = data_reg;
      ch_next    = ch_reg;
      if (reg_free) begin
         valid_next = 1'b0;
         if (mode == MODE_MANUAL) begin
            valid_next = 1'b1;
            data_next  = sel_ok ? ch_data[sel] : '0;
            ch_next    = sel;
         end else if (strobe) begin
            valid_next = 1'b1;
            data_next  = ch_data[samp_ch];
            ch_next    = samp_ch;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
         ch_reg    <= '0;
      end else begin
         valid_reg <= valid_next;
         data_reg  <= data_next;
         ch_reg    <= ch_next;
      end
   end

   assign out_valid = valid_reg;
   assign out_data  = data_reg;
   assign out_ch    = ch_reg;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Scoreboard bench for mux_scan_reg: behavioural model pushes expected samples, monitor checks accepts.
module tb_mux_scan_reg;

   localparam int N_CH  = 4;
   localparam int W     = 8;
   localparam int DWELL = 3;
   localparam int SEL_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              mode;
   logic [SEL_W-1:0]  sel;
   logic [N_CH*W-1:0] in_data;
   logic [N_CH-1:0]   mask;
   logic              out_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [SEL_W-1:0]  out_ch;

   always #5 clk = ~clk;

   mux_scan_reg #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask   (mask),
`endif
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch)
   );

   typedef struct {
      int data;
      int ch;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   bit   done  = 0;

   // model state: output register occupancy, scan position, dwell count, last mode seen
   bit m_valid;
   int m_ptr;
   int m_cnt;
   bit m_mode_prev;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int chan(input int k);
      logic [N_CH*W-1:0] t;
      t = in_data >> (k * W);
      return int'(t[W-1:0]);
   endfunction

   // Predict the effect of the coming clock edge from the current inputs.
   task automatic model_step();
      bit   free;
      bit   load;
      int   c;
      exp_t e;
      load = 0;
      if (rst) begin
         m_valid = 0; m_ptr = 0; m_cnt = 0; m_mode_prev = mode;
         exp_q.delete();
         return;
      end
      free = !m_valid || out_ready;
      if (mode == 1'b0) begin
         m_ptr = 0; m_cnt = 0;
         if (free) begin
            load = 1;
            e.ch = int'(sel);
            e.data = (int'(sel) < N_CH && mask[sel]) ? chan(int'(sel)) : 0;
         end
      end else if (mode != m_mode_prev) begin
         m_ptr = 0; m_cnt = 0;
      end else if (m_cnt == DWELL - 1) begin
         if (free && mask != 0) begin
            c = -1;
            for (int k = 0; k < N_CH; k++)
               if (c < 0 && mask[(m_ptr + k) % N_CH]) c = (m_ptr + k) % N_CH;
            load = 1; e.ch = c; e.data = chan(c);
            m_ptr = c;
            for (int k = N_CH; k >= 1; k--)
               if (mask[(c + k) % N_CH]) m_ptr = (c + k) % N_CH;
            m_cnt = 0;
         end
      end else begin
         m_cnt = m_cnt + 1;
      end
      if (free) m_valid = load;
      if (load) begin
         e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
      m_mode_prev = mode;
   endtask

   task automatic cycle(input bit r, input bit m, input int s, input bit rdy);
      rst = r; mode = m; sel = SEL_W'(s); out_ready = rdy;
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset();
      tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
         fails++;
         $display("FAIL reset_state: got valid=%b data=%h ch=%0d, want valid=0 data=00 ch=0",
                  out_valid, out_data, out_ch);
      end else begin
         $display("[TB] reset ok at cyc %0d", cyc);
      end
   endtask

   // Monitor: one scoreboard pop per accepted transfer.
   initial begin : monitor
      bit   fresh;
      int   load_cyc;
      exp_t e;
      fresh = 1; load_cyc = 0;
      forever begin
         @(negedge clk);
         if (!done) begin
            if (rst === 1'b1) begin
               fresh = 1;
            end else if (out_valid === 1'b1) begin
               if (fresh) begin load_cyc = cyc; fresh = 0; end
               if (out_ready === 1'b1) begin
                  tests++;
                  if (exp_q.size() == 0) begin
                     fails++;
                     $display("FAIL sample: got data=%h ch=%0d loaded cyc %0d, want no sample",
                              out_data, out_ch, load_cyc);
                  end else begin
                     e = exp_q.pop_front();
                     if (int'(out_data) != e.data || int'(out_ch) != e.ch || load_cyc != e.cyc) begin
                        fails++;
                        $display("FAIL sample: got data=%h ch=%0d cyc=%0d, want data=%h ch=%0d cyc=%0d",
                                 out_data, out_ch, load_cyc, e.data, e.ch, e.cyc);
                     end else begin
                        $display("[TB] sample data=%h ch=%0d cyc=%0d", out_data, out_ch, load_cyc);
                     end
                  end
                  fresh = 1;
               end
            end else begin
               fresh = 1;
            end
         end
      end
   end

   initial begin : driver
      in_data = {8'h44, 8'h33, 8'h22, 8'h11};
      mask = '1;
      sel = '0; out_ready = 1'b1; mode = 1'b1; rst = 1'b1;
      #1;

      // reset with scan selected, then scan wrap
      cycle(1, 1, 0, 1);
      cycle(1, 1, 0, 1);
      check_reset();
      for (int i = 0; i < 15; i++) cycle(0, 1, 0, 1);

      // manual select
      cycle(0, 0, 2, 1);
      cycle(0, 0, 3, 1);
      cycle(0, 0, 1, 1);

      // backpressure after first scan sample
      cycle(1, 1, 0, 1);
      check_reset();
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1);
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, 1);

      // mode switch mid-scan, then back
      cycle(1, 1, 0, 1);
      for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1);
      cycle(0, 0, 3, 1);
      for (int i = 0; i < 8; i++) cycle(0, 1, 0, 1);

      // reset while a stalled sample is pending
      cycle(0, 0, 2, 0);
      cycle(0, 0, 2, 0);
      cycle(1, 0, 2, 0);
      check_reset();

`ifdef MUX_SCAN_MASK_EN
      mask = 4'b1010;
      for (int i = 0; i < 15; i++) cycle(0, 1, 0, 1);
      cycle(0, 0, 0, 1);
      mask = 4'b0000;
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1);
      mask = '1;
`endif

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) in_data = {$urandom, $urandom} >> 32;
`ifdef MUX_SCAN_MASK_EN
         if ($urandom_range(0, 19) == 0) mask = N_CH'($urandom);
`endif
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 19) == 0) ? !mode : mode,
               int'($urandom_range(0, N_CH - 1)),
               ($urandom_range(0, 9) < 7));
         if (rst) check_reset();
      end

      // final occupancy: only the sample still in the register may remain expected
      done = 1;
      tests++;
      if (out_valid !== m_valid || exp_q.size() != int'(m_valid) ||
          (m_valid && (int'(out_data) != exp_q[0].data || int'(out_ch) != exp_q[0].ch))) begin
         fails++;
         $display("FAIL final_state: got valid=%b data=%h, want valid=%b pending=%0d",
                  out_valid, out_data, m_valid, exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
